// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared AXI crossbar encodings and misroute responder state type
//
// Contents:
//   RESP_OKAY / RESP_DECERR : AXI response encodings
//   mr_state_t              : misroute responder FSM states
package axicb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } mr_state_t;

endpackage

// File: rtl/axicb_scfifo.sv
// rtl/axicb_scfifo.sv - single-clock register-file FIFO
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (empties the FIFO)
//   push/wdata : write strobe and data (ignored when full)
//   pop        : read strobe (ignored when empty)
//   rdata      : head entry (valid while !empty)
//   full/empty : occupancy flags
module axicb_scfifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axicb_mr_responder.sv
// rtl/axicb_mr_responder.sv - terminating DECERR responder for misrouted AXI requests
//
// Optional build macro: AXICB_MR_RDATA_PATTERN_EN (read data = 8'hDE repeated, else 0)
//
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset
//   srst            : synchronous active-high clear
//   a_valid/a_ready : misrouted AR/AW request handshake; a_id, a_len payload
//   w_valid/w_ready : write data sink (write responder only), w_last ends burst
//   c_valid/c_ready : completion handshake (R beats or B)
//   c_id, c_resp    : completion ID and response (DECERR while valid)
//   c_last, c_data  : RLAST / always 1 for B, RDATA
module axicb_mr_responder #(
  parameter int RD_PATH         = 0,
  parameter int AXI_ID_W        = 8,
  parameter int AXI_DATA_W      = 8,
  parameter int MST_OSTDREQ_NUM = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [AXI_ID_W-1:0]   a_id,
  input  logic [7:0]            a_len,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic                  w_last,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [AXI_ID_W-1:0]   c_id,
  output logic [1:0]            c_resp,
  output logic                  c_last,
  output logic [AXI_DATA_W-1:0] c_data
);

  import axicb_pkg::*;

  localparam int QDEPTH = (MST_OSTDREQ_NUM < 2) ? 2 : MST_OSTDREQ_NUM;
  localparam int EW     = 8 + AXI_ID_W;

`ifdef AXICB_MR_RDATA_PATTERN_EN
  localparam logic [AXI_DATA_W-1:0] RDATA_FILL = {(AXI_DATA_W/8){8'hDE}};
`else
  localparam logic [AXI_DATA_W-1:0] RDATA_FILL = '0;
`endif

  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic [EW-1:0] q_rdata;

  mr_state_t             state;
  logic [7:0]            cnt;
  logic [7:0]            len;
  logic [AXI_ID_W-1:0]   id_q;

  assign a_ready = !q_full;
  assign q_push  = a_valid && a_ready;
  // The head entry is consumed at the same edge the FSM leaves IDLE.
  assign q_pop   = (state == ST_IDLE) && !q_empty && !srst;

  axicb_scfifo #(
    .DW    (EW),
    .DEPTH (QDEPTH)
  ) u_req_q (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (srst),
    .push  (q_push),
    .wdata ({a_len, a_id}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len     <= '0;
      id_q    <= '0;
      w_ready <= 1'b0;
      c_valid <= 1'b0;
      c_last  <= 1'b0;
      c_resp  <= RESP_OKAY;
      c_id    <= '0;
      c_data  <= '0;
    end else if (srst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len     <= '0;
      id_q    <= '0;
      w_ready <= 1'b0;
      c_valid <= 1'b0;
      c_last  <= 1'b0;
      c_resp  <= RESP_OKAY;
      c_id    <= '0;
      c_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            id_q  <= q_rdata[AXI_ID_W-1:0];
            len   <= q_rdata[EW-1 -: 8];
            cnt   <= '0;
            state <= (RD_PATH != 0) ? ST_BURST : ST_DRAIN;
          end
        end

        // First BURST cycle arms the registered outputs; afterwards they
        // only move on a completed handshake so the payload stays stable.
        ST_BURST: begin
          if (!c_valid) begin
            c_valid <= 1'b1;
            c_last  <= (cnt == len);
            c_resp  <= RESP_DECERR;
            c_id    <= id_q;
            c_data  <= RDATA_FILL;
          end else if (c_ready) begin
            if (c_last) begin
              c_valid <= 1'b0;
              c_last  <= 1'b0;
              c_resp  <= RESP_OKAY;
              c_id    <= '0;
              c_data  <= '0;
              state   <= ST_IDLE;
            end else begin
              // Terminates at cnt == len, so len = 255 never wraps cnt.
              cnt    <= cnt + 8'd1;
              c_last <= ((cnt + 8'd1) == len);
            end
          end
        end

        ST_DRAIN: begin
          if (!w_ready) begin
            w_ready <= 1'b1;
          end else if (w_valid) begin
            cnt <= cnt + 8'd1;
            if (w_last) begin
              w_ready <= 1'b0;
              c_valid <= 1'b1;
              c_last  <= 1'b1;
              c_resp  <= RESP_DECERR;
              c_id    <= id_q;
              state   <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (c_ready) begin
            c_valid <= 1'b0;
            c_last  <= 1'b0;
            c_resp  <= RESP_OKAY;
            c_id    <= '0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axicb_mr_responder.sv
// tb/tb_axicb_mr_responder.sv - directed self-checking bench for axicb_mr_responder
module tb_axicb_mr_responder;

  logic aclk;
  logic aresetn;
  logic srst;

  logic        rd_a_valid, rd_a_ready, rd_w_valid, rd_w_ready, rd_w_last;
  logic [7:0]  rd_a_id, rd_a_len, rd_c_id;
  logic        rd_c_valid, rd_c_ready, rd_c_last;
  logic [1:0]  rd_c_resp;
  logic [31:0] rd_c_data;

  logic        wr_a_valid, wr_a_ready, wr_w_valid, wr_w_ready, wr_w_last;
  logic [7:0]  wr_a_id, wr_a_len, wr_c_id;
  logic        wr_c_valid, wr_c_ready, wr_c_last;
  logic [1:0]  wr_c_resp;
  logic [7:0]  wr_c_data;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AXICB_MR_RDATA_PATTERN_EN
  localparam logic [31:0] EXP_RDATA = 32'hDEDEDEDE;
`else
  localparam logic [31:0] EXP_RDATA = 32'h0;
`endif

  axicb_mr_responder #(
    .RD_PATH(1), .AXI_ID_W(8), .AXI_DATA_W(32), .MST_OSTDREQ_NUM(4)
  ) u_rd (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .a_valid(rd_a_valid), .a_ready(rd_a_ready), .a_id(rd_a_id), .a_len(rd_a_len),
    .w_valid(rd_w_valid), .w_ready(rd_w_ready), .w_last(rd_w_last),
    .c_valid(rd_c_valid), .c_ready(rd_c_ready), .c_id(rd_c_id),
    .c_resp(rd_c_resp), .c_last(rd_c_last), .c_data(rd_c_data)
  );

  axicb_mr_responder #(
    .RD_PATH(0), .AXI_ID_W(8), .AXI_DATA_W(8), .MST_OSTDREQ_NUM(4)
  ) u_wr (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .a_valid(wr_a_valid), .a_ready(wr_a_ready), .a_id(wr_a_id), .a_len(wr_a_len),
    .w_valid(wr_w_valid), .w_ready(wr_w_ready), .w_last(wr_w_last),
    .c_valid(wr_c_valid), .c_ready(wr_c_ready), .c_id(wr_c_id),
    .c_resp(wr_c_resp), .c_last(wr_c_last), .c_data(wr_c_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; srst = 1'b0;
    rd_a_valid = 0; rd_a_id = 0; rd_a_len = 0; rd_w_valid = 0; rd_w_last = 0; rd_c_ready = 0;
    wr_a_valid = 0; wr_a_id = 0; wr_a_len = 0; wr_w_valid = 0; wr_w_last = 0; wr_c_ready = 0;
    repeat (3) step();
    aresetn = 1'b1;
    step();
    n_checks++; if (rd_c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_c_valid got %b exp 0", rd_c_valid); end
    n_checks++; if (rd_c_resp !== 2'b00) begin n_fail++; $display("FAIL reset_rd_c_resp got %b exp 00", rd_c_resp); end
    n_checks++; if (rd_c_id !== 8'h00) begin n_fail++; $display("FAIL reset_rd_c_id got %h exp 00", rd_c_id); end
    n_checks++; if (rd_c_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_c_last got %b exp 0", rd_c_last); end
    n_checks++; if (rd_c_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_c_data got %h exp 0", rd_c_data); end
    n_checks++; if (rd_a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rd_a_ready got %b exp 1", rd_a_ready); end
    n_checks++; if (rd_w_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_w_ready got %b exp 0", rd_w_ready); end
    n_checks++; if (wr_w_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_w_ready got %b exp 0", wr_w_ready); end
    n_checks++; if (wr_c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_c_valid got %b exp 0", wr_c_valid); end
    n_checks++; if (wr_a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_a_ready got %b exp 1", wr_a_ready); end
  endtask

  task automatic test_rd_single;
    int beats = 0;
    int last_at = -1;
    int bad = 0;
    rd_c_ready = 1'b1;
    rd_a_valid = 1'b1; rd_a_id = 8'h05; rd_a_len = 8'd3;
    step();  // handshake edge k
    rd_a_valid = 1'b0;
    n_checks++; if (rd_c_valid !== 1'b0) begin n_fail++; $display("FAIL rd_lat_k got %b exp 0", rd_c_valid); end
    step();
    n_checks++; if (rd_c_valid !== 1'b0) begin n_fail++; $display("FAIL rd_lat_k1 got %b exp 0", rd_c_valid); end
    step();
    n_checks++; if (rd_c_valid !== 1'b1) begin n_fail++; $display("FAIL rd_lat_k2 got %b exp 1", rd_c_valid); end
    for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
      if (rd_c_valid) begin
        if (rd_c_id !== 8'h05 || rd_c_resp !== 2'b11 || rd_c_data !== EXP_RDATA) bad++;
        if (rd_c_last) last_at = beats;
        beats++;
      end
      step();
    end
    n_checks++; if (beats !== 4) begin n_fail++; $display("FAIL rd_single_beats got %0d exp 4", beats); end
    n_checks++; if (last_at !== 3) begin n_fail++; $display("FAIL rd_single_last_beat got %0d exp 3", last_at); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rd_single_payload bad_beats=%0d exp 0 (id 05 resp 3 data %h)", bad, EXP_RDATA); end
    n_checks++; if (rd_c_data !== 32'h0) begin n_fail++; $display("FAIL rd_idle_data got %h exp 0", rd_c_data); end
  endtask

  task automatic test_rd_back_to_back;
    logic [7:0] lens [5]   = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd2};
    logic [7:0] exp_id [8] = '{8'h20, 8'h21, 8'h22, 8'h22, 8'h23, 8'h24, 8'h24, 8'h24};
    logic       exp_lst [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int beats = 0;
    rd_c_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_a_valid = 1'b1; rd_a_id = 8'h20 + 8'(i); rd_a_len = lens[i];
      n_checks++; if (rd_a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_a_ready_push%0d got %b exp 1", i, rd_a_ready); end
      step();
    end
    rd_a_valid = 1'b0;
    n_checks++; if (rd_a_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_ready_full got %b exp 0", rd_a_ready); end
    rd_c_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
      if (cyc == 1) begin
        n_checks++; if (rd_a_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_ready_before_pop got %b exp 0", rd_a_ready); end
      end
      if (cyc == 2) begin
        n_checks++; if (rd_a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_a_ready_after_pop got %b exp 1", rd_a_ready); end
      end
      if (rd_c_valid) begin
        n_checks++;
        if (rd_c_id !== exp_id[beats] || rd_c_last !== exp_lst[beats] || rd_c_resp !== 2'b11) begin
          n_fail++;
          $display("FAIL b2b_beat%0d got id %h last %b resp %b exp id %h last %b resp 11",
                   beats, rd_c_id, rd_c_last, rd_c_resp, exp_id[beats], exp_lst[beats]);
        end
        beats++;
      end
      step();
    end
    n_checks++; if (beats !== 8) begin n_fail++; $display("FAIL b2b_total_beats got %0d exp 8", beats); end
  endtask

  task automatic test_rd_long;
    int beats = 0;
    int last_at = -1;
    int unstable = 0;
    int extra = 0;
    int bad = 0;
    logic stalled = 1'b0;
    logic [42:0] held = '0;
    rd_c_ready = 1'b0;
    rd_a_valid = 1'b1; rd_a_id = 8'h33; rd_a_len = 8'd255;
    step();
    rd_a_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && beats < 256; cyc++) begin
      if (stalled) begin
        if (!rd_c_valid || {rd_c_id, rd_c_resp, rd_c_last, rd_c_data} !== held) unstable++;
      end
      rd_c_ready = ($urandom_range(0, 2) != 0);
      stalled = 1'b0;
      if (rd_c_valid) begin
        if (rd_c_ready) begin
          if (rd_c_id !== 8'h33 || rd_c_resp !== 2'b11) bad++;
          if (rd_c_last) begin
            if (last_at < 0) last_at = beats;
          end
          beats++;
        end else begin
          stalled = 1'b1;
          held = {rd_c_id, rd_c_resp, rd_c_last, rd_c_data};
        end
      end
      step();
    end
    rd_c_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (rd_c_valid) extra++;
      step();
    end
    n_checks++; if (beats !== 256) begin n_fail++; $display("FAIL rd_long_beats got %0d exp 256", beats); end
    n_checks++; if (last_at !== 255) begin n_fail++; $display("FAIL rd_long_last_beat got %0d exp 255", last_at); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL rd_long_stall_stable violations=%0d exp 0", unstable); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rd_long_payload bad_beats=%0d exp 0", bad); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rd_long_no_extra_beats got %0d exp 0", extra); end
  endtask

  task automatic test_wr_burst;
    int beats = 0;
    int early_b = 0;
    wr_c_ready = 1'b0;
    wr_w_valid = 1'b1; wr_w_last = 1'b0;
    step();
    step();
    n_checks++; if (wr_w_ready !== 1'b0) begin n_fail++; $display("FAIL wr_w_before_aw got %b exp 0", wr_w_ready); end
    wr_a_valid = 1'b1; wr_a_id = 8'h0A; wr_a_len = 8'd7;
    step();  // handshake edge k
    wr_a_valid = 1'b0;
    n_checks++; if (wr_w_ready !== 1'b0) begin n_fail++; $display("FAIL wr_lat_k got %b exp 0", wr_w_ready); end
    step();
    n_checks++; if (wr_w_ready !== 1'b0) begin n_fail++; $display("FAIL wr_lat_k1 got %b exp 0", wr_w_ready); end
    step();
    n_checks++; if (wr_w_ready !== 1'b1) begin n_fail++; $display("FAIL wr_lat_k2 got %b exp 1", wr_w_ready); end
    for (int cyc = 0; cyc < 50 && beats < 5; cyc++) begin
      if (wr_c_valid) early_b++;
      if (wr_w_ready) begin
        wr_w_last = (beats == 4);
        beats++;
      end
      step();
    end
    wr_w_valid = 1'b0; wr_w_last = 1'b0;
    n_checks++; if (beats !== 5) begin n_fail++; $display("FAIL wr_beats got %0d exp 5", beats); end
    n_checks++; if (early_b !== 0) begin n_fail++; $display("FAIL wr_b_before_wlast got %0d exp 0", early_b); end
    n_checks++;
    if (wr_c_valid !== 1'b1 || wr_c_id !== 8'h0A || wr_c_resp !== 2'b11 || wr_c_last !== 1'b1 || wr_w_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_b_resp got valid %b id %h resp %b last %b w_ready %b exp 1 0a 11 1 0",
               wr_c_valid, wr_c_id, wr_c_resp, wr_c_last, wr_w_ready);
    end
    n_checks++; if (wr_c_data !== 8'h00) begin n_fail++; $display("FAIL wr_c_data got %h exp 00", wr_c_data); end
    wr_c_ready = 1'b1;
    step();
    n_checks++; if (wr_c_valid !== 1'b0) begin n_fail++; $display("FAIL wr_b_after_hs got %b exp 0", wr_c_valid); end
    early_b = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (wr_c_valid || wr_w_ready) early_b++;
      step();
    end
    n_checks++; if (early_b !== 0) begin n_fail++; $display("FAIL wr_single_b extra_activity=%0d exp 0", early_b); end
  endtask

  task automatic test_wr_srst;
    int act = 0;
    wr_c_ready = 1'b1;
    wr_a_valid = 1'b1; wr_a_id = 8'h0B;
    step();
    wr_a_id = 8'h0C;
    step();
    wr_a_valid = 1'b0;
    step();
    n_checks++; if (wr_w_ready !== 1'b1) begin n_fail++; $display("FAIL srst_drain_entry got %b exp 1", wr_w_ready); end
    wr_w_valid = 1'b1; wr_w_last = 1'b0;
    step();
    step();
    srst = 1'b1; wr_w_valid = 1'b0;
    step();
    srst = 1'b0;
    n_checks++; if (wr_w_ready !== 1'b0) begin n_fail++; $display("FAIL srst_w_ready got %b exp 0", wr_w_ready); end
    n_checks++; if (wr_c_valid !== 1'b0) begin n_fail++; $display("FAIL srst_c_valid got %b exp 0", wr_c_valid); end
    n_checks++; if (wr_a_ready !== 1'b1) begin n_fail++; $display("FAIL srst_a_ready got %b exp 1", wr_a_ready); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (wr_w_ready || wr_c_valid) act++;
      step();
    end
    n_checks++; if (act !== 0) begin n_fail++; $display("FAIL srst_queue_empty activity=%0d exp 0", act); end
  endtask

  initial begin
    test_reset();
    test_rd_single();
    test_rd_back_to_back();
    test_rd_long();
    test_wr_burst();
    test_wr_srst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
